lenet_conv1_engine: RTL and testbench
=====================================

Name: lenet_conv1_engine

Overview:
- LeNet-5 first-layer accelerator: 5x5 convolution, ReLU, requantisation and 2x2 max-pool.
- Input is a 32x32 int8 image; weights are 6 int8 5x5 kernels; output is 6 channels of 14x14 int8.
- Reads image and weights from two BRAMs and writes the packed result to a third.
- Controlled by a start pulse and a done level from the host.

Parameters:
- QSHIFT, 7, arithmetic right shift applied to the 32-bit accumulator before saturation.
- BASE_IF, 0, byte base address of the image in the IF BRAM.
- BASE_W, 0, byte base address of the weights in the W BRAM.
- BASE_TEMP, 0, byte base address of the output in the TEMP BRAM.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse that begins one layer computation.
- done  out  1  high when the layer is complete; held until the next start.
- BRAM_IF_ADDR, BRAM_W_ADDR, BRAM_TEMP_ADDR  out  32  byte addresses, word aligned (bits 1:0 = 0).
- BRAM_IF_EN, BRAM_W_EN, BRAM_TEMP_EN  out  1  port enables.
- BRAM_IF_WE, BRAM_W_WE, BRAM_TEMP_WE  out  4  byte write enables.
- BRAM_IF_RST, BRAM_W_RST, BRAM_TEMP_RST  out  1  BRAM output resets; always 0.
- BRAM_IF_DOUT, BRAM_W_DOUT, BRAM_TEMP_DOUT  in  32  BRAM read data.
- BRAM_IF_DIN, BRAM_W_DIN, BRAM_TEMP_DIN  out  32  BRAM write data.

Behaviour:
- Reset (rst=0, asynchronous): all outputs 0, FSM in IDLE, accumulators cleared. Reset mid-run aborts the run; no further writes occur.
- BRAM timing: read data is valid on DOUT one cycle after EN=1 with ADDR applied.
- IF and W ports are read-only: WE=0 and DIN=0 at all times.
- Byte packing: little-endian, so byte k of a word is bits 8k+7:8k.
- Image layout: pixel (r,c) is signed int8 at byte r*32+c; 256 words.
- Weight layout: kernel ch, tap (i,j) is signed int8 at byte ch*25+i*5+j; 150 bytes in 38 words; the pad bytes of word 37 are ignored.
- Output layout: channel ch, pooled position (pr,pc) is one byte at byte index ch*196+pr*14+pc; 1176 bytes = 294 words, every word written with WE=4'hF.
- IDLE: waits for start. start pulses outside IDLE/DONE are ignored.
- LOAD_W: reads the 38 weight words into an internal 150-byte register file.
- CONV: for each (ch,pr,pc) and each of its 4 pool sub-positions (dy,dx):
  - acc = sum of signed img(2pr+dy+i, 2pc+dx+j) * w(ch,i,j), 32-bit signed;
  - requantise: q = sat(acc >>> QSHIFT) to the range given by the optional feature;
  - pooled value = maximum of the 4 q values.
- Image fetch: one word read per tap; the pixel byte is selected by address bits 1:0. At most 2 cycles per MAC.
- PACK/WRITE: pooled bytes are collected in order ch, pr, pc. Each completed word of 4 bytes is written to TEMP at BASE_TEMP + 4*word_idx.
- DONE: done=1, all EN=0; returns to IDLE on the next start (done clears that cycle).
- Total latency is at most 250000 cycles from start to done.
- No bias term is added.

Optional Feature:
- CNN_RELU_EN defined (default build; golden vectors use it): q is saturated to 0..127, so negative results become 0.
- CNN_RELU_EN undefined: q is saturated to -128..127, and max-pool compares signed values.

Decomposition:
- Package lenet_conv1_pkg:
  - constants IMG_W=32, K=5, N_CH=6, CONV_W=28, POOL_W=14, W_WORDS=38, OUT_WORDS=294;
  - FSM state enum IDLE/LOAD_W/CONV/WRITE/DONE.
- One sub-module, conv1_mac_unit: signed 8x8 MAC, shift, saturate and ReLU.
- The top level holds the FSM, address generation, weight register file and output packer.

Test Plan:
- All-zero image with random weights -> TEMP words 0..293 all 0x00000000; done rises once and stays high.
- All-ones image, all kernels w=1 (0x01010101 words), QSHIFT=0 -> every output byte 25, every word 0x19191919.
- Single pixel img(0,0)=127, kernel 0 tap(0,0)=127, QSHIFT=7 -> 16129>>>7=126:
  - word 0 byte 0 = 0x7E;
  - all other bytes 0.
- Negative weights (all 0xFF) with all-ones image -> all outputs 0x00 with CNN_RELU_EN; 0xFF when built without it.
- Reset asserted mid-CONV -> outputs go to 0 immediately, no TEMP writes after reset; a new start completes correctly.
- Random image and weights vs. reference model -> all 294 words match; IF/W WE never nonzero.

Source files
------------

// File: rtl/lenet_conv1_pkg.sv
// lenet_conv1_pkg: geometry constants, FSM encoding and a small helper for the
// LeNet-5 conv1 engine (5x5 conv, requantise, 2x2 max-pool).
package lenet_conv1_pkg;
  localparam int IMG_W     = 32;
  localparam int K         = 5;
  localparam int N_CH      = 6;
  localparam int CONV_W    = 28;
  localparam int POOL_W    = 14;
  localparam int W_WORDS   = 38;
  localparam int OUT_WORDS = 294;

  typedef enum logic [2:0] {IDLE, LOAD_W, CONV, WRITE, DONE} state_e;

  function automatic logic signed [7:0] smax8(input logic signed [7:0] a,
                                              input logic signed [7:0] b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/lenet_conv1_engine_mac.sv
// conv1_mac_unit: signed 8x8 multiply-accumulate with arithmetic right shift and
// saturation. Build option CNN_RELU_EN clamps to 0..127, otherwise -128..127.
module conv1_mac_unit #(
  parameter int QSHIFT = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              mac_en,
  input  logic              mac_clr,
  input  logic signed [7:0] pix,
  input  logic signed [7:0] wt,
  output logic signed [7:0] q
);
  logic signed [31:0] acc_q, acc_d;
  logic signed [31:0] shifted;
  logic signed [15:0] prod;

  always_comb begin
    prod  = pix * wt;
    acc_d = acc_q;
    if (mac_en) acc_d = (mac_clr ? '0 : acc_q) + {{16{prod[15]}}, prod};
  end

  always_comb begin
    shifted = acc_q >>> QSHIFT;
`ifdef CNN_RELU_EN
    if (shifted < 0) q = '0;
`else
    if (shifted < -32'sd128) q = 8'sh80;
`endif
    else if (shifted > 32'sd127) q = 8'sh7F;
    else q = shifted[7:0];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end
endmodule

// File: rtl/lenet_conv1_engine.sv
// lenet_conv1_engine: FSM, BRAM address generation, weight register file and
// output packer around conv1_mac_unit. Requantiser range set by CNN_RELU_EN.
module lenet_conv1_engine
  import lenet_conv1_pkg::*;
#(
  parameter int QSHIFT    = 7,
  parameter int BASE_IF   = 0,
  parameter int BASE_W    = 0,
  parameter int BASE_TEMP = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        done,
  output logic [31:0] BRAM_IF_ADDR,
  output logic        BRAM_IF_EN,
  output logic [3:0]  BRAM_IF_WE,
  output logic        BRAM_IF_RST,
  input  logic [31:0] BRAM_IF_DOUT,
  output logic [31:0] BRAM_IF_DIN,
  output logic [31:0] BRAM_W_ADDR,
  output logic        BRAM_W_EN,
  output logic [3:0]  BRAM_W_WE,
  output logic        BRAM_W_RST,
  input  logic [31:0] BRAM_W_DOUT,
  output logic [31:0] BRAM_W_DIN,
  output logic [31:0] BRAM_TEMP_ADDR,
  output logic        BRAM_TEMP_EN,
  output logic [3:0]  BRAM_TEMP_WE,
  output logic        BRAM_TEMP_RST,
  input  logic [31:0] BRAM_TEMP_DOUT,
  output logic [31:0] BRAM_TEMP_DIN
);
  state_e state_q, state_d;
  logic [5:0]             wcnt_q, wcnt_d;
  logic [W_WORDS*32-1:0]  wmem_q, wmem_d;
  logic [2:0] ch_q, ch_d, ti_q, ti_d, tj_q, tj_d;
  logic [3:0] pr_q, pr_d, pc_q, pc_d;
  logic [1:0] sub_q, sub_d;
  // stage 1: read issued, data on DOUT; stage 2 (fin): accumulator final
  logic       v1_q, v1_d, clr1_q, clr1_d, last1_q, last1_d;
  logic       s0_1_q, s0_1_d, s3_1_q, s3_1_d;
  logic [1:0] bsel1_q, bsel1_d;
  logic [7:0] wt1_q, wt1_d;
  logic       fin_q, fin_d, fs0_q, fs0_d, fs3_q, fs3_d;
  logic signed [7:0] pool_q, pool_d, pooled, q;
  logic [23:0] pack_q, pack_d;
  logic [1:0]  bcnt_q, bcnt_d;
  logic [8:0]  ocnt_q, ocnt_d;
  logic        temp_en_q, temp_en_d;
  logic [31:0] temp_addr_q, temp_addr_d, temp_din_q, temp_din_d;
  logic        if_en, w_en;
  logic [4:0]  row, col;
  logic [7:0]  widx;
  logic [31:0] pix_addr, w_addr;
  logic [7:0]  pix;
  logic        unused_temp_dout;

  assign unused_temp_dout = ^BRAM_TEMP_DOUT;

  always_comb begin
    row      = {pr_q, 1'b0} + {4'd0, sub_q[1]} + {2'd0, ti_q};
    col      = {pc_q, 1'b0} + {4'd0, sub_q[0]} + {2'd0, tj_q};
    pix_addr = 32'(BASE_IF) + {22'd0, row, col};
    w_addr   = 32'(BASE_W) + {24'd0, wcnt_q, 2'b00};
    widx     = 8'(ch_q) * 8'd25 + 8'(ti_q) * 8'd5 + 8'(tj_q);
    pix      = BRAM_IF_DOUT[{bsel1_q, 3'b000} +: 8];
  end

  conv1_mac_unit #(.QSHIFT(QSHIFT)) u_mac (
    .clk     (clk),
    .rst_n   (rst),
    .mac_en  (v1_q),
    .mac_clr (clr1_q),
    .pix     (pix),
    .wt      (wt1_q),
    .q       (q)
  );

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    wmem_d  = wmem_q;
    ch_d = ch_q; pr_d = pr_q; pc_d = pc_q; sub_d = sub_q; ti_d = ti_q; tj_d = tj_q;
    v1_d = 1'b0; clr1_d = 1'b0; last1_d = 1'b0; s0_1_d = 1'b0; s3_1_d = 1'b0;
    bsel1_d = '0; wt1_d = '0;
    if_en = 1'b0;
    w_en  = 1'b0;
    unique case (state_q)
      IDLE, DONE: begin
        if (start) begin
          state_d = LOAD_W;
          wcnt_d  = '0;
        end
      end
      LOAD_W: begin
        // word n is issued at count n and lands in the register file at count n+1
        if (wcnt_q != '0) wmem_d[{wcnt_q - 6'd1, 5'b00000} +: 32] = BRAM_W_DOUT;
        if (wcnt_q == 6'(W_WORDS)) begin
          state_d = CONV;
          ch_d = '0; pr_d = '0; pc_d = '0; sub_d = '0; ti_d = '0; tj_d = '0;
        end else begin
          w_en   = 1'b1;
          wcnt_d = wcnt_q + 6'd1;
        end
      end
      CONV: begin
        if_en   = 1'b1;
        v1_d    = 1'b1;
        bsel1_d = pix_addr[1:0];
        wt1_d   = wmem_q[{widx, 3'b000} +: 8];
        clr1_d  = (ti_q == '0) && (tj_q == '0);
        last1_d = (ti_q == 3'(K-1)) && (tj_q == 3'(K-1));
        s0_1_d  = (sub_q == 2'd0);
        s3_1_d  = (sub_q == 2'd3);
        tj_d    = tj_q + 3'd1;
        if (tj_q == 3'(K-1)) begin
          tj_d = '0;
          ti_d = ti_q + 3'd1;
          if (ti_q == 3'(K-1)) begin
            ti_d  = '0;
            sub_d = sub_q + 2'd1;
            if (sub_q == 2'd3) begin
              pc_d = pc_q + 4'd1;
              if (pc_q == 4'(POOL_W-1)) begin
                pc_d = '0;
                pr_d = pr_q + 4'd1;
                if (pr_q == 4'(POOL_W-1)) begin
                  pr_d = '0;
                  ch_d = ch_q + 3'd1;
                  if (ch_q == 3'(N_CH-1)) state_d = WRITE;
                end
              end
            end
          end
        end
      end
      WRITE: begin
        if (ocnt_q == 9'(OUT_WORDS)) state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    fin_d       = v1_q & last1_q;
    fs0_d       = s0_1_q;
    fs3_d       = s3_1_q;
    pool_d      = pool_q;
    pack_d      = pack_q;
    bcnt_d      = bcnt_q;
    ocnt_d      = ocnt_q;
    temp_en_d   = 1'b0;
    temp_addr_d = temp_addr_q;
    temp_din_d  = temp_din_q;
    pooled      = fs0_q ? q : smax8(pool_q, q);
    if (state_q == LOAD_W) begin
      bcnt_d = '0;
      ocnt_d = '0;
    end
    if (fin_q) begin
      pool_d = pooled;
      if (fs3_q) begin
        if (bcnt_q == 2'd3) begin
          temp_en_d   = 1'b1;
          temp_din_d  = {pooled, pack_q};
          temp_addr_d = {32'(BASE_TEMP) + {21'd0, ocnt_q, 2'b00}} & 32'hFFFF_FFFC;
          ocnt_d      = ocnt_q + 9'd1;
          bcnt_d      = '0;
        end else begin
          pack_d[{bcnt_q, 3'b000} +: 8] = pooled;
          bcnt_d = bcnt_q + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
      wmem_q  <= '0;
      ch_q <= '0; pr_q <= '0; pc_q <= '0; sub_q <= '0; ti_q <= '0; tj_q <= '0;
      v1_q <= 1'b0; clr1_q <= 1'b0; last1_q <= 1'b0; s0_1_q <= 1'b0; s3_1_q <= 1'b0;
      bsel1_q <= '0; wt1_q <= '0;
      fin_q <= 1'b0; fs0_q <= 1'b0; fs3_q <= 1'b0;
      pool_q <= '0; pack_q <= '0; bcnt_q <= '0; ocnt_q <= '0;
      temp_en_q <= 1'b0; temp_addr_q <= '0; temp_din_q <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      wmem_q  <= wmem_d;
      ch_q <= ch_d; pr_q <= pr_d; pc_q <= pc_d; sub_q <= sub_d; ti_q <= ti_d; tj_q <= tj_d;
      v1_q <= v1_d; clr1_q <= clr1_d; last1_q <= last1_d; s0_1_q <= s0_1_d; s3_1_q <= s3_1_d;
      bsel1_q <= bsel1_d; wt1_q <= wt1_d;
      fin_q <= fin_d; fs0_q <= fs0_d; fs3_q <= fs3_d;
      pool_q <= pool_d; pack_q <= pack_d; bcnt_q <= bcnt_d; ocnt_q <= ocnt_d;
      temp_en_q <= temp_en_d; temp_addr_q <= temp_addr_d; temp_din_q <= temp_din_d;
    end
  end

  assign done           = (state_q == DONE);
  assign BRAM_IF_EN     = if_en;
  assign BRAM_IF_ADDR   = if_en ? {pix_addr[31:2], 2'b00} : '0;
  assign BRAM_IF_WE     = '0;
  assign BRAM_IF_DIN    = '0;
  assign BRAM_IF_RST    = 1'b0;
  assign BRAM_W_EN      = w_en;
  assign BRAM_W_ADDR    = w_en ? {w_addr[31:2], 2'b00} : '0;
  assign BRAM_W_WE      = '0;
  assign BRAM_W_DIN     = '0;
  assign BRAM_W_RST     = 1'b0;
  assign BRAM_TEMP_EN   = temp_en_q;
  assign BRAM_TEMP_ADDR = temp_en_q ? temp_addr_q : '0;
  assign BRAM_TEMP_WE   = {4{temp_en_q}};
  assign BRAM_TEMP_DIN  = temp_en_q ? temp_din_q : '0;
  assign BRAM_TEMP_RST  = 1'b0;
endmodule

// File: tb/tb_lenet_conv1_engine.sv
// tb_lenet_conv1_engine: BRAM models, behavioural conv/ReLU/pool reference and
// directed + random layer runs for lenet_conv1_engine (honours CNN_RELU_EN).
module tb_lenet_conv1_engine;
  localparam int QS = 7;
`ifdef CNN_RELU_EN
  localparam int LO = 0;
  localparam logic [31:0] NEG_WORD = 32'h0000_0000;
`else
  localparam int LO = -128;
  localparam logic [31:0] NEG_WORD = 32'hFFFF_FFFF;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic done;
  logic [31:0] BRAM_IF_ADDR, BRAM_IF_DOUT, BRAM_IF_DIN;
  logic [31:0] BRAM_W_ADDR, BRAM_W_DOUT, BRAM_W_DIN;
  logic [31:0] BRAM_TEMP_ADDR, BRAM_TEMP_DOUT, BRAM_TEMP_DIN;
  logic        BRAM_IF_EN, BRAM_W_EN, BRAM_TEMP_EN;
  logic        BRAM_IF_RST, BRAM_W_RST, BRAM_TEMP_RST;
  logic [3:0]  BRAM_IF_WE, BRAM_W_WE, BRAM_TEMP_WE;

  always #5 clk = ~clk;

  lenet_conv1_engine #(.QSHIFT(QS), .BASE_IF(0), .BASE_W(0), .BASE_TEMP(0)) dut (
    .clk(clk), .rst(rst), .start(start), .done(done),
    .BRAM_IF_ADDR(BRAM_IF_ADDR), .BRAM_IF_EN(BRAM_IF_EN), .BRAM_IF_WE(BRAM_IF_WE),
    .BRAM_IF_RST(BRAM_IF_RST), .BRAM_IF_DOUT(BRAM_IF_DOUT), .BRAM_IF_DIN(BRAM_IF_DIN),
    .BRAM_W_ADDR(BRAM_W_ADDR), .BRAM_W_EN(BRAM_W_EN), .BRAM_W_WE(BRAM_W_WE),
    .BRAM_W_RST(BRAM_W_RST), .BRAM_W_DOUT(BRAM_W_DOUT), .BRAM_W_DIN(BRAM_W_DIN),
    .BRAM_TEMP_ADDR(BRAM_TEMP_ADDR), .BRAM_TEMP_EN(BRAM_TEMP_EN), .BRAM_TEMP_WE(BRAM_TEMP_WE),
    .BRAM_TEMP_RST(BRAM_TEMP_RST), .BRAM_TEMP_DOUT(BRAM_TEMP_DOUT), .BRAM_TEMP_DIN(BRAM_TEMP_DIN)
  );

  logic [31:0] if_mem [256];
  logic [31:0] w_mem [38];
  logic [31:0] temp_mem [294];
  logic signed [7:0] img_b [1024];
  logic signed [7:0] w_b [152];
  logic [31:0] exp_w [294];
  int errors = 0, checks = 0;
  int wr_cnt = 0, wr_bad = 0, ro_bad = 0, done_rises = 0;
  logic prev_done = 1'b0;

  assign BRAM_TEMP_DOUT = '0;

  always @(posedge clk) begin
    if (BRAM_IF_EN) BRAM_IF_DOUT <= if_mem[BRAM_IF_ADDR[9:2]];
    if (BRAM_W_EN) BRAM_W_DOUT <= (BRAM_W_ADDR[31:2] < 38) ? w_mem[BRAM_W_ADDR[7:2]] : 32'hXXXX_XXXX;
    if (BRAM_TEMP_EN) begin
      if (BRAM_TEMP_WE != 4'hF || BRAM_TEMP_ADDR[31:2] >= 294 || BRAM_TEMP_ADDR[1:0] != 2'b00)
        wr_bad++;
      else
        temp_mem[BRAM_TEMP_ADDR[10:2]] = BRAM_TEMP_DIN;
      wr_cnt++;
    end
    if (done && !prev_done) done_rises++;
    prev_done = done;
  end

  always @(negedge clk) begin
    if (BRAM_IF_WE != 4'h0 || BRAM_W_WE != 4'h0 || BRAM_IF_DIN != 32'h0 || BRAM_W_DIN != 32'h0 ||
        BRAM_IF_RST || BRAM_W_RST || BRAM_TEMP_RST)
      ro_bad++;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_quiet(input string tag);
    chk({tag, " done"}, {31'd0, done}, 32'd0);
    chk({tag, " en"}, {29'd0, BRAM_IF_EN, BRAM_W_EN, BRAM_TEMP_EN}, 32'd0);
    chk({tag, " temp_we"}, {28'd0, BRAM_TEMP_WE}, 32'd0);
    chk({tag, " addr"}, BRAM_IF_ADDR | BRAM_W_ADDR | BRAM_TEMP_ADDR, 32'd0);
  endtask

  task automatic load_mems();
    for (int k = 0; k < 256; k++)
      if_mem[k] = {img_b[4*k+3], img_b[4*k+2], img_b[4*k+1], img_b[4*k]};
    for (int k = 0; k < 38; k++)
      w_mem[k] = {w_b[4*k+3], w_b[4*k+2], w_b[4*k+1], w_b[4*k]};
  endtask

  // Reference: direct 5x5 convolution per pool sub-position, shift, clamp, max of four.
  task automatic build_expected();
    logic [7:0] outb [1176];
    int acc, q, best, a, b;
    for (int ch = 0; ch < 6; ch++)
      for (int pr = 0; pr < 14; pr++)
        for (int pc = 0; pc < 14; pc++) begin
          best = -100000;
          for (int s = 0; s < 4; s++) begin
            acc = 0;
            for (int i = 0; i < 5; i++)
              for (int j = 0; j < 5; j++) begin
                a = img_b[(2*pr + s/2 + i)*32 + 2*pc + s%2 + j];
                b = w_b[ch*25 + i*5 + j];
                acc += a * b;
              end
            q = acc >>> QS;
            if (q > 127) q = 127;
            if (q < LO) q = LO;
            if (q > best) best = q;
          end
          outb[ch*196 + pr*14 + pc] = 8'(best);
        end
    for (int k = 0; k < 294; k++)
      exp_w[k] = {outb[4*k+3], outb[4*k+2], outb[4*k+1], outb[4*k]};
  endtask

  task automatic pulse_start(input string tag);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk({tag, " done low after start"}, {31'd0, done}, 32'd0);
  endtask

  task automatic run_layer(input string tag);
    int cyc;
    for (int k = 0; k < 294; k++) temp_mem[k] = 32'hDEAD_BEEF;
    wr_cnt = 0;
    done_rises = 0;
    pulse_start(tag);
    cyc = 1;
    while (!done && cyc < 250000) begin
      @(negedge clk);
      cyc++;
    end
    chk({tag, " done within budget"}, {31'd0, done}, 32'd1);
    repeat (5) @(negedge clk);
    chk({tag, " done held"}, {31'd0, done}, 32'd1);
    chk({tag, " done rises"}, done_rises, 32'd1);
    chk({tag, " write count"}, wr_cnt, 32'd294);
  endtask

  task automatic compare_all(input string tag);
    for (int k = 0; k < 294; k++)
      chk($sformatf("%s word%0d", tag, k), temp_mem[k], exp_w[k]);
  endtask

  typedef struct { int idx; logic [31:0] exp; } vec_t;
  vec_t tbl [11];

  initial begin
    int cyc, pre;
    tbl[0]  = '{0,   32'h0000_007E};
    tbl[1]  = '{1,   32'h0000_0000};
    tbl[2]  = '{48,  32'h0000_0000};
    tbl[3]  = '{49,  32'h1818_187F};
    tbl[4]  = '{50,  32'h1818_1818};
    tbl[5]  = '{97,  32'h1818_1818};
    tbl[6]  = '{98,  32'h1818_187F};
    tbl[7]  = '{146, 32'h1818_1818};
    tbl[8]  = '{147, NEG_WORD};
    tbl[9]  = '{200, NEG_WORD};
    tbl[10] = '{293, NEG_WORD};

    repeat (3) @(negedge clk);
    chk_quiet("reset");
    rst = 1'b1;
    @(negedge clk);

    // Structured layer: ones image with a 127 corner, mixed positive/negative kernels.
    for (int k = 0; k < 1024; k++) img_b[k] = 8'sd1;
    img_b[0] = 8'sd127;
    for (int k = 0; k < 152; k++) w_b[k] = 8'sh00;
    w_b[0] = 8'sd127;
    for (int k = 25; k < 75; k++) w_b[k] = 8'sd127;
    for (int k = 75; k < 150; k++) w_b[k] = -8'sd1;
    w_b[150] = 8'shAA;
    w_b[151] = 8'sh55;
    load_mems();
    build_expected();
    run_layer("directed");
    foreach (tbl[n])
      chk($sformatf("table word%0d", tbl[n].idx), temp_mem[tbl[n].idx], tbl[n].exp);
    compare_all("directed");

    // Random layer, aborted by reset mid-convolution, then rerun to completion.
    for (int k = 0; k < 1024; k++) img_b[k] = 8'($urandom);
    for (int k = 0; k < 152; k++) w_b[k] = 8'($urandom);
    load_mems();
    build_expected();
    wr_cnt = 0;
    pulse_start("abort");
    cyc = 0;
    while (!BRAM_IF_EN && cyc < 1000) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort reached conv", {31'd0, BRAM_IF_EN}, 32'd1);
    repeat (3000) @(negedge clk);
    chk("abort writes before reset", {31'd0, wr_cnt > 0}, 32'd1);
    #2 rst = 1'b0;
    #1 chk_quiet("midrun reset");
    pre = wr_cnt;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (50) @(negedge clk);
    chk("no writes after reset", wr_cnt, pre);
    chk("idle after reset done", {31'd0, done}, 32'd0);
    run_layer("rerun");
    compare_all("random");

    chk("read-only ports quiet", ro_bad, 32'd0);
    chk("temp write format", wr_bad, 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
